nrisc_data_mem_ctrl: RTL and testbench
======================================

Name: nrisc_data_mem_ctrl

Overview:
- Responder end of the NRISC CPU data-memory interface. Accepts the CPU's DATA_IN / CORE_DATA_ADDR / CORE_DATA_write / CORE_DATA_load strobes and returns DATA_Out.
- Sits between the CPU and a single-port synchronous SRAM with 1-cycle read latency.
- Posts writes into a small FIFO so the CPU never waits on writes. Reads bypass the FIFO, with store-to-load forwarding.

Parameters:
- TAM, 16, data and CPU address width.
- NWbuf, 4, write-buffer depth in entries; a power of 2, at least 2.
- AW, 10, SRAM address width; the SRAM uses CORE_DATA_ADDR[AW-1:0].

Ports:
- clk  in  1  main clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- DATA_IN  in  TAM  write data from CPU.
- CORE_DATA_ADDR  in  TAM  address from CPU.
- CORE_DATA_write  in  1  one write request per cycle high.
- CORE_DATA_load  in  1  one read request per cycle high.
- DATA_Out  out  TAM  read data to CPU; registered.
- DATA_busy  out  1  write buffer full.
- DATA_ovf  out  1  sticky flag: a write was dropped.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write enable; meaningful only when sram_en=1.
- sram_addr  out  AW  SRAM address.
- sram_wdata  out  TAM  SRAM write data.
- sram_rdata  in  TAM  SRAM read data, valid one cycle after a read.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied, read state returns to RD_IDLE.
  - DATA_Out=0, DATA_busy=0, DATA_ovf=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
  - Reset mid-drain or mid-read abandons the operation; buffered writes are lost.
- Write buffer: circular FIFO of {addr[AW-1:0], data}, with head/tail pointers and a count.
  - Write accepted only if count<NWbuf at the start of the cycle.
  - Write while full is dropped and DATA_ovf sets. It is dropped even if a drain occurs in the same cycle.
  - DATA_busy = (count==NWbuf), registered, updated every cycle.
- SRAM port arbitration, evaluated each cycle:
  1. A load that misses the buffer issues an SRAM read: sram_en=1, sram_we=0, sram_addr=CORE_DATA_ADDR[AW-1:0].
  2. Otherwise, if the buffer is non-empty, the head entry drains: sram_en=1, sram_we=1, head's addr/data, head advances, count decrements.
  3. Otherwise sram_en=0.
  - A load always wins over a drain.
- Forwarding lookup:
  - On a load, CORE_DATA_ADDR[AW-1:0] is compared against all valid buffer entries.
  - On one or more matches, the youngest match (nearest tail) is used; no SRAM read is issued, and a drain may proceed in that cycle.
  - An entry draining in the same cycle still counts as valid for the lookup.
- Read state machine:
  - RD_IDLE: on a hit, capture the forwarded data into a hold register and go to RD_FWD. On a miss, go to RD_SRAM. With no load, stay.
  - RD_FWD: DATA_Out <= hold register.
  - RD_SRAM: DATA_Out <= sram_rdata.
  - From RD_FWD or RD_SRAM, a new load in the same cycle re-enters RD_FWD or RD_SRAM. That gives back-to-back loads one per cycle.
  - Read latency is 2 posedges for both paths: DATA_Out updates on the 2nd posedge after the load cycle.
  - DATA_Out holds its value until the next read completes.
- Simultaneous load and write in the same cycle:
  - The lookup sees the buffer before the enqueue, so the read returns the older value.
  - The write is then enqueued.
- Width rules:
  - Upper address bits [TAM-1:AW] are ignored, so addresses alias modulo 2^AW.
  - Pointers wrap modulo NWbuf.
  - count is $clog2(NWbuf)+1 bits.
- Load and write both high with the buffer full: the read proceeds normally and the write is dropped.

Decomposition:
- Shared package nrisc_mem_pkg:
  - read-state enum {RD_IDLE, RD_SRAM, RD_FWD};
  - localparams for the default TAM, AW and NWbuf;
  - a write-entry struct {addr, data}.
- One natural sub-module: nrisc_wbuf. It holds the FIFO storage, pointers, count and full flag, and the parallel youngest-match lookup with hit and hit-data outputs.
- Arbitration, the read FSM and the output registers stay in the top module.

Test Plan:
- Reset: hold rst for 2 cycles with write=1 -> all outputs 0, no SRAM activity, count=0.
- Post and drain: write addr 0x0010 data 0xBEEF, then idle -> sram_en=1, we=1, addr=0x010, wdata=0xBEEF one cycle after the write cycle; buffer then empty.
- Forwarding: write 0x0020=0x1111, then 0x0020=0x2222, then load 0x0020 the next cycle -> DATA_Out=0x2222 after 2 posedges, no SRAM read issued.
- Miss priority: 3 writes queued, then load 0x0005 with SRAM[5]=0xA5A5 -> SRAM read issued that cycle with no drain; DATA_Out=0xA5A5 2 posedges later; drain resumes next cycle.
- Overflow: 5 consecutive writes with continuous loads blocking drains (NWbuf=4) -> DATA_busy=1 after the 4th write, 5th dropped, DATA_ovf=1 and stays 1 until rst.
- Same-cycle load+write: SRAM[0x30]=0x0001; in one cycle, load 0x0030 and write 0x0030=0x0002 -> DATA_Out=0x0001; a load the next cycle returns 0x0002.

Source files
------------

// File: rtl/nrisc_mem_pkg.sv
// Shared types and default sizes for the NRISC data-memory controller.
package nrisc_mem_pkg;

  localparam int unsigned TamDefault   = 16;
  localparam int unsigned AwDefault    = 10;
  localparam int unsigned NwbufDefault = 4;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_SRAM,
    RD_FWD
  } rd_state_e;

  // Default-width view of one posted write.
  typedef struct packed {
    logic [AwDefault-1:0]  addr;
    logic [TamDefault-1:0] data;
  } wentry_t;

endpackage

// File: rtl/nrisc_wbuf.sv
// Posted-write FIFO with a parallel youngest-match lookup for store-to-load forwarding.
module nrisc_wbuf
  import nrisc_mem_pkg::*;
#(
  parameter int unsigned TAM   = TamDefault,
  parameter int unsigned AW    = AwDefault,
  parameter int unsigned NWbuf = NwbufDefault
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [AW-1:0]  push_addr,
  input  logic [TAM-1:0] push_data,
  input  logic           pop,
  output logic [AW-1:0]  head_addr,
  output logic [TAM-1:0] head_data,
  output logic           empty,
  output logic           full,
  input  logic [AW-1:0]  lookup_addr,
  output logic           hit,
  output logic [TAM-1:0] hit_data
);

  localparam int unsigned PW = $clog2(NWbuf);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [TAM-1:0] data;
  } entry_t;

  entry_t        mem_q [NWbuf];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q;
  logic          do_push, do_pop;
  logic [PW-1:0] idx;

  assign empty   = (count_q == '0);
  assign full    = full_q;
  // A write arriving while full is refused even if the head drains this cycle.
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  assign head_addr = mem_q[head_q].addr;
  assign head_data = mem_q[head_q].data;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (do_push) tail_q <= tail_q + PW'(1);
      if (do_pop)  head_q <= head_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(NWbuf));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[tail_q] <= '{addr: push_addr, data: push_data};
    end
  end

  // Walk oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < NWbuf; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (mem_q[idx].addr == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = mem_q[idx].data;
      end
    end
  end

endmodule

// File: rtl/nrisc_data_mem_ctrl.sv
// NRISC data-memory responder: posted writes, SRAM arbitration and a two-cycle read pipeline.
module nrisc_data_mem_ctrl
  import nrisc_mem_pkg::*;
#(
  parameter int unsigned TAM   = TamDefault,
  parameter int unsigned NWbuf = NwbufDefault,
  parameter int unsigned AW    = AwDefault
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TAM-1:0] DATA_IN,
  input  logic [TAM-1:0] CORE_DATA_ADDR,
  input  logic           CORE_DATA_write,
  input  logic           CORE_DATA_load,
  output logic [TAM-1:0] DATA_Out,
  output logic           DATA_busy,
  output logic           DATA_ovf,
  output logic           sram_en,
  output logic           sram_we,
  output logic [AW-1:0]  sram_addr,
  output logic [TAM-1:0] sram_wdata,
  input  logic [TAM-1:0] sram_rdata
);

  logic [AW-1:0]  ld_addr;
  logic           unused_addr_hi;
  logic           wb_empty, wb_full, wb_hit;
  logic [AW-1:0]  wb_head_addr;
  logic [TAM-1:0] wb_head_data, wb_hit_data;
  logic           load_miss, drain;

  rd_state_e      rd_state_q, rd_state_d;
  logic [TAM-1:0] hold_q, hold_d;
  logic [TAM-1:0] data_out_q, data_out_d;
  logic           ovf_q;

  // Upper address bits alias away.
  assign ld_addr        = CORE_DATA_ADDR[AW-1:0];
  assign unused_addr_hi = ^CORE_DATA_ADDR[TAM-1:AW];

  assign load_miss = CORE_DATA_load && !wb_hit;
  assign drain     = !rst && !load_miss && !wb_empty;

  nrisc_wbuf #(
    .TAM  (TAM),
    .AW   (AW),
    .NWbuf(NWbuf)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .push       (CORE_DATA_write),
    .push_addr  (ld_addr),
    .push_data  (DATA_IN),
    .pop        (drain),
    .head_addr  (wb_head_addr),
    .head_data  (wb_head_data),
    .empty      (wb_empty),
    .full       (wb_full),
    .lookup_addr(ld_addr),
    .hit        (wb_hit),
    .hit_data   (wb_hit_data)
  );

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!rst) begin
      if (load_miss) begin
        sram_en   = 1'b1;
        sram_addr = ld_addr;
      end else if (!wb_empty) begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = wb_head_addr;
        sram_wdata = wb_head_data;
      end
    end
  end

  // Completion of the previous load and acceptance of a new one share a cycle.
  always_comb begin
    rd_state_d = RD_IDLE;
    hold_d     = hold_q;
    data_out_d = data_out_q;
    case (rd_state_q)
      RD_FWD:  data_out_d = hold_q;
      RD_SRAM: data_out_d = sram_rdata;
      default: ;
    endcase
    if (CORE_DATA_load) begin
      if (wb_hit) begin
        rd_state_d = RD_FWD;
        hold_d     = wb_hit_data;
      end else begin
        rd_state_d = RD_SRAM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      hold_q     <= '0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      hold_q     <= hold_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_q | (CORE_DATA_write & wb_full);
    end
  end

  assign DATA_Out  = data_out_q;
  assign DATA_busy = wb_full;
  assign DATA_ovf  = ovf_q;

endmodule

// File: tb/tb_nrisc_data_mem_ctrl.sv
// Scoreboard bench for nrisc_data_mem_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_nrisc_data_mem_ctrl;
  import nrisc_mem_pkg::*;

  localparam int unsigned TAM   = TamDefault;
  localparam int unsigned AW    = AwDefault;
  localparam int unsigned NWBUF = NwbufDefault;

  typedef struct {
    int             due;
    logic [TAM-1:0] val;
  } pend_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [TAM-1:0] DATA_IN, CORE_DATA_ADDR;
  logic           CORE_DATA_write, CORE_DATA_load;
  logic [TAM-1:0] DATA_Out;
  logic           DATA_busy, DATA_ovf;
  logic           sram_en, sram_we;
  logic [AW-1:0]  sram_addr;
  logic [TAM-1:0] sram_wdata, sram_rdata;

  logic [TAM-1:0] sram_mem [1 << AW];
  logic [TAM-1:0] ref_view [1 << AW];
  wentry_t        wbuf_m [$];
  pend_t          pend_q [$];
  logic [TAM-1:0] last_out;
  logic           ovf_m;
  int             cyc;
  int             n_vec;
  int             n_err;

  always #5 clk = ~clk;

  nrisc_data_mem_ctrl #(
    .TAM  (TAM),
    .NWbuf(NWBUF),
    .AW   (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .DATA_IN        (DATA_IN),
    .CORE_DATA_ADDR (CORE_DATA_ADDR),
    .CORE_DATA_write(CORE_DATA_write),
    .CORE_DATA_load (CORE_DATA_load),
    .DATA_Out       (DATA_Out),
    .DATA_busy      (DATA_busy),
    .DATA_ovf       (DATA_ovf),
    .sram_en        (sram_en),
    .sram_we        (sram_we),
    .sram_addr      (sram_addr),
    .sram_wdata     (sram_wdata),
    .sram_rdata     (sram_rdata)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= '0;
      sram_mem[5]  <= 16'hA5A5;
      sram_mem[48] <= 16'h0001;
      sram_rdata   <= '0;
    end else if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  // One bus cycle: drive, check against the model, then advance the model.
  task automatic step(input logic ld, input logic [TAM-1:0] la, input logic wr,
                      input logic [TAM-1:0] wa, input logic [TAM-1:0] wd);
    logic [AW-1:0]  a;
    logic           hit, acc, e_en, e_we;
    logic [AW-1:0]  e_addr;
    logic [TAM-1:0] e_wd;
    pend_t          p;
    @(negedge clk);
    CORE_DATA_load  = ld;
    CORE_DATA_ADDR  = ld ? la : wa;
    CORE_DATA_write = wr;
    DATA_IN         = wd;
    if (ld && wr && (la[AW-1:0] != wa[AW-1:0])) $display("bench note: load/write share one address bus");
    #1;
    a   = CORE_DATA_ADDR[AW-1:0];
    hit = 1'b0;
    foreach (wbuf_m[i]) if (wbuf_m[i].addr == a) hit = 1'b1;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (ld && !hit) begin
      e_en = 1'b1; e_addr = a;
    end else if (wbuf_m.size() > 0) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = wbuf_m[0].addr; e_wd = wbuf_m[0].data;
    end
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      p = pend_q.pop_front();
      last_out = p.val;
    end
    check_eq("data_out", DATA_Out, last_out);
    check_eq("busy", DATA_busy, wbuf_m.size() == NWBUF);
    check_eq("ovf", DATA_ovf, ovf_m);
    check_eq("sram_en", sram_en, e_en);
    if (e_en) begin
      check_eq("sram_we", sram_we, e_we);
      check_eq("sram_addr", sram_addr, e_addr);
      if (e_we) check_eq("sram_wdata", sram_wdata, e_wd);
    end
    if (ld) pend_q.push_back('{due: cyc + 2, val: ref_view[a]});
    acc = wr && (wbuf_m.size() < NWBUF);
    if (wr && !acc) ovf_m = 1'b1;
    if (e_en && e_we) void'(wbuf_m.pop_front());
    if (acc) begin
      wbuf_m.push_back('{addr: a, data: wd});
      ref_view[a] = wd;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  // The controller shares CORE_DATA_ADDR between load and write, so tests use one address.
  task automatic ldwr(input logic ld, input logic wr, input logic [TAM-1:0] ad,
                      input logic [TAM-1:0] wd);
    step(ld, ad, wr, ad, wd);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; last_out = '0; ovf_m = 1'b0;
    for (int i = 0; i < (1 << AW); i++) ref_view[i] = '0;
    ref_view[5]  = 16'hA5A5;
    ref_view[48] = 16'h0001;

    rst = 1'b1; CORE_DATA_write = 1'b1; CORE_DATA_load = 1'b0;
    CORE_DATA_ADDR = 16'h0077; DATA_IN = 16'hABCD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_data_out", DATA_Out, 0);
    check_eq("rst_busy", DATA_busy, 0);
    check_eq("rst_ovf", DATA_ovf, 0);
    check_eq("rst_sram_en", sram_en, 0);
    check_eq("rst_sram_we", sram_we, 0);
    check_eq("rst_sram_addr", sram_addr, 0);
    check_eq("rst_sram_wdata", sram_wdata, 0);
    rst = 1'b0; CORE_DATA_write = 1'b0;
    idle(2);

    // Post and drain.
    ldwr(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    idle(2);

    // Forwarding of the youngest of two writes to one address.
    ldwr(1'b0, 1'b1, 16'h0020, 16'h1111);
    ldwr(1'b0, 1'b1, 16'h0020, 16'h2222);
    ldwr(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(3);

    // Miss priority: misses hold off drains while three writes queue up.
    ldwr(1'b1, 1'b1, 16'h0100, 16'h0A01);
    ldwr(1'b1, 1'b1, 16'h0101, 16'h0A02);
    ldwr(1'b1, 1'b1, 16'h0102, 16'h0A03);
    ldwr(1'b1, 1'b0, 16'h0005, 16'h0000);
    idle(5);

    // Overflow: continuous misses block drains.
    for (int i = 0; i < 5; i++) ldwr(1'b1, 1'b1, 16'h0040 + 16'(i), 16'h5000 + 16'(i));
    idle(6);

    // Same-cycle load and write to one address, then a follow-up load.
    ldwr(1'b1, 1'b1, 16'h0030, 16'h0002);
    ldwr(1'b1, 1'b0, 16'h0030, 16'h0000);
    idle(3);

    // Aliasing of upper address bits, forwarded and after drain.
    ldwr(1'b0, 1'b1, 16'h0410, 16'h7777);
    ldwr(1'b1, 1'b0, 16'hFC10, 16'h0000);
    idle(3);
    ldwr(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(3);

    // Random mix over a small aliased address window.
    for (int i = 0; i < 300; i++) begin
      ldwr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           {6'($urandom_range(0, 63)), 10'($urandom_range(0, 7))}, 16'($urandom));
    end
    idle(8);
    check_eq("pending_drained", pend_q.size(), 0);
    check_eq("ovf_sticky", DATA_ovf, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
